// File: rtl/mul_seq_pkg.sv
// Shared types, defaults and helpers for the multiplier job sequencer.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CLEAR  = 2'b01,
    LAUNCH = 2'b10,
    WAIT   = 2'b11
  } state_t;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned MAX_WAIT_DEF = 64;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mul_job_sequencer_if.sv
// Operand, multiplier-control and result streams of the job sequencer.
interface mul_job_sequencer_if #(
  parameter int unsigned N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           mul_clr;
  logic           mul_start;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_ready;
  logic [2*N-1:0] mul_product;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic           timeout_err;

  modport master (
    input  in_valid, in_a, in_b, mul_ready, mul_product, out_ready,
    output in_ready, mul_clr, mul_start, mul_a, mul_b, out_valid, out_product, timeout_err
  );

  modport slave (
    output in_valid, in_a, in_b, mul_ready, mul_product, out_ready,
    input  in_ready, mul_clr, mul_start, mul_a, mul_b, out_valid, out_product, timeout_err
  );
endinterface

// File: rtl/mul_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push is ignored when full, pop when empty.
module mul_seq_fifo
  import mul_seq_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned IW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[IW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mul_job_sequencer.sv
// Drives a one-shot start/ready multiplier from an operand FIFO and presents results on a
// back-pressured stream. Optional WAIT timeout is enabled by defining MUL_SEQ_TIMEOUT_EN.
module mul_job_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mul_job_sequencer_if.master io
);
  state_t         state_q, state_d;
  logic           head_seen_q, head_seen_d;
  logic           out_valid_q, out_valid_d;
  logic [2*N-1:0] out_product_q, out_product_d;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [2*N-1:0] head;
  logic           room, capture, force_done;

  mul_seq_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io.in_valid),
    .pop   (fifo_pop),
    .wdata ({io.in_a, io.in_b}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (head)
  );

  assign room     = !out_valid_q || io.out_ready;
  assign capture  = (state_q == WAIT) && io.mul_ready && room;
  assign fifo_pop = capture || force_done;

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  assign force_done = (state_q == WAIT) && !io.mul_ready && room &&
                      (wait_cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q || force_done;
    if (state_q == LAUNCH) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT && wait_cnt_q != CW'(MAX_WAIT - 1)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  assign io.timeout_err = timeout_err_q;
`else
  logic unused_max_wait;
  assign unused_max_wait = |MAX_WAIT;
  assign force_done      = 1'b0;
  assign io.timeout_err  = 1'b0;
`endif

  // head_seen_q delays the start of a job by one cycle after the FIFO first turns
  // non-empty; a stale value right after a pop is masked by the live empty flag.
  always_comb begin
    state_d       = state_q;
    head_seen_d   = !fifo_empty;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;

    if (out_valid_q && io.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE:    if (!fifo_empty && head_seen_q) state_d = CLEAR;
      CLEAR:   state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (fifo_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      out_valid_d   = 1'b1;
      out_product_d = io.mul_product;
    end else if (force_done) begin
      out_valid_d   = 1'b1;
      out_product_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      head_seen_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      head_seen_q   <= head_seen_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
`ifdef MUL_SEQ_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign io.in_ready             = !fifo_full;
  assign io.mul_clr              = (state_q == CLEAR);
  assign io.mul_start            = (state_q == LAUNCH);
  assign {io.mul_a, io.mul_b}    = head;
  assign io.out_valid            = out_valid_q;
  assign io.out_product          = out_product_q;

endmodule

// File: doc/mul_job_sequencer.md
# mul_job_sequencer

Job sequencer wrapped around the sequential shift-add multiplier. Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. Runs one multiplication at a time: clears the multiplier, pulses its start, waits for its ready, then captures the product. Presents the product on a valid/ready result stream, so the multiplier's one-shot start/ready protocol becomes a back-pressured pipeline stage.

## Interface
- N, 4, operand width; product width is 2N
- DEPTH, 4, operand FIFO entries; power of two, at least 2
- MAX_WAIT, 64, timeout limit in WAIT cycles; used only with MUL_SEQ_TIMEOUT_EN

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept; equals !full
- in_a  in  N  multiplicand
- in_b  in  N  multiplier
- mul_clr  out  1  one-cycle clear pulse; OR'd into the multiplier's rst at top level
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a  out  N  FIFO head multiplicand; stable from LAUNCH until pop
- mul_b  out  N  FIFO head multiplier; stable from LAUNCH until pop
- mul_ready  in  1  multiplier done (level; held until cleared)
- mul_product  in  2N  multiplier result; valid while mul_ready=1
- out_valid  out  1  result register holds a product
- out_ready  in  1  downstream accepts
- out_product  out  2N  captured product
- timeout_err  out  1  sticky timeout flag

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b} to the FIFO tail.
- in_ready depends only on full; there is no same-cycle pop bypass when full.
- FSM states (state_t): IDLE, CLEAR, LAUNCH, WAIT.
  - IDLE → CLEAR when the FIFO is non-empty; otherwise stay in IDLE.
  - CLEAR → LAUNCH unconditionally. mul_clr=1 in CLEAR only.
  - LAUNCH → WAIT unconditionally. mul_start=1 in LAUNCH only.
  - WAIT → IDLE on capture. Otherwise stay in WAIT.
- Capture condition: state=WAIT && mul_ready && (!out_valid || out_ready).
- On capture:
  - out_product ← mul_product and out_valid ← 1.
  - The FIFO pops its head.
- mul_ready is ignored outside WAIT. CLEAR guarantees that a stale ready from the previous job is gone before LAUNCH.
- Result register:
  - out_valid clears on out_valid && out_ready, unless a capture happens in the same cycle; then it stays 1 with the new product.
  - out_product holds its value while out_valid && !out_ready.
- Back-pressure: if the result register is full and not draining, the FSM stays in WAIT with mul_ready high and the FIFO is not popped.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- Arithmetic: the block does no arithmetic. mul_product passes through at full 2N width with no truncation.
- FIFO pointers are log2(DEPTH)+1 bits with wrap bit. empty = pointers equal; full = indexes equal and wrap bits differ.

## Timing
- Reset values: state=IDLE, FIFO empty, in_ready=1, mul_clr=0, mul_start=0, out_valid=0, out_product=0, timeout_err=0.
- mul_a and mul_b reflect whatever the empty FIFO head holds; don't-care until LAUNCH.
- Reset mid-operation discards the FIFO contents, any job in flight, and any unconsumed result.
- mul_clr and mul_start are decoded from the registered state: each is high for exactly one cycle per job, and they never overlap.
- Latency for a push at edge t into an empty, idle block:
  - CLEAR is entered at edge t+2.
  - LAUNCH is entered at edge t+3.
  - WAIT is entered at edge t+4.
  - out_valid rises at the first edge in WAIT where mul_ready=1.
- Throughput: one job per (3 + multiplier latency) cycles, with no stall from the result side.

## Configuration
- MUL_SEQ_TIMEOUT_EN defined:
  - A counter resets on entry to WAIT and increments each WAIT cycle.
  - When it reaches MAX_WAIT without mul_ready, the job is forced complete with out_product=0, the head is popped, and timeout_err is set.
  - The forced completion obeys the same result-register-free condition as a normal capture.
  - timeout_err stays at 1 until rst.
- MUL_SEQ_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, and timeout_err is tied to 0.

## Structure
- Package mul_seq_pkg holds:
  - state_t enum (IDLE=2'b00, CLEAR=2'b01, LAUNCH=2'b10, WAIT=2'b11)
  - default N, DEPTH and MAX_WAIT localparams
  - the clog2-based pointer width helper
- Sub-module mul_seq_fifo: a parameterised synchronous FIFO (push, pop, full, empty, head data). The FSM, result register and timeout logic stay in the top module.

## Test plan
- Single job: push a=3, b=5; the multiplier model asserts ready 6 cycles after start.
  - Required: mul_clr at t+2, mul_start at t+3, out_product=15 one edge after ready, out_valid held until out_ready.
- Fill: push 4 pairs back-to-back with out_ready=0.
  - Required: in_ready drops after the 4th push, the first result stalls in the result register, the second job stalls in WAIT, a 5th push is refused.
  - Release out_ready: products arrive in order.
- Full boundary: with the FIFO full and a pop occurring, drive in_valid.
  - Required: no push that cycle; in_ready returns to 1 the next cycle.
- Continuous drain: out_ready=1 with pairs (15,15), (0,7), (1,1).
  - Required: products 225, 0, 1 in order; each completion drains the previous product in the same cycle.
- Reset in WAIT: assert rst mid-job.
  - Required: all outputs reach their reset values at once; the next push behaves as a fresh single job.
- Timeout (macro on, MAX_WAIT=8): the model never asserts ready.
  - Required: after 8 WAIT cycles, out_product=0, out_valid=1, timeout_err=1 and stays 1.
